bus_share_arb2: RTL

Two-requester round-robin arbiter that shares one 32-bit datapath select (2:1 word multiplexer) and a registered result slot between two producers. It computes the select each cycle and sequences valid/ready handshakes on both input sides and on the output side. It also keeps per-requester grant counts for debug. It sits in front of any shared 32-bit consumer, for example a register-file write port or a result bus.

---
 rtl/bus_share_arb2_pkg.sv | 16 +
 rtl/bus_share_arb2_if.sv | 29 ++
 rtl/bus_share_arb2_rr_pick2.sv | 25 ++
 rtl/bus_share_arb2.sv | 92 +++++++++
 4 files changed

// File: rtl/bus_share_arb2_pkg.sv
// Shared constants and types for the two-requester result-slot arbiter.
package bus_share_arb2_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNTW  = 16;

   // Source encoding shared by out_src and lastGrant
   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

endpackage

// File: rtl/bus_share_arb2_if.sv
// Handshake and result bundle between two producers, the arbiter and one consumer.
interface bus_share_arb2_if #(
   parameter int WIDTH = bus_share_arb2_pkg::DEF_WIDTH,
   parameter int CNTW  = bus_share_arb2_pkg::DEF_CNTW
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic             req1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready;
   logic             cnt_clr;
   logic [CNTW-1:0]  grant_cnt0;
   logic [CNTW-1:0]  grant_cnt1;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready, cnt_clr,
      output req0_ready, req1_ready, out_valid, out_data, out_src, grant_cnt0, grant_cnt1
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready, cnt_clr,
      input  req0_ready, req1_ready, out_valid, out_data, out_src, grant_cnt0, grant_cnt1
   );
endinterface

// File: rtl/bus_share_arb2_rr_pick2.sv
// Two-way round-robin winner pick; with no winner the index parks on lastGrant
// so the downstream word select stays put.
module rr_pick2
   import bus_share_arb2_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic lastGrant,
   output logic grantVld,
   output logic grantIdx
);

   always_comb begin
      grantVld = valid0 || valid1;
      grantIdx = lastGrant;
      if (valid0 && valid1) begin
         grantIdx = ~lastGrant;
      end else if (valid0) begin
         grantIdx = SRC_REQ0;
      end else if (valid1) begin
         grantIdx = SRC_REQ1;
      end
   end

endmodule

// File: rtl/bus_share_arb2.sv
// Round-robin share of one registered result slot between two producers,
// with saturating per-requester grant counters.
module bus_share_arb2
   import bus_share_arb2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNTW  = DEF_CNTW
) (
   input  logic             clk,
   input  logic             rst_n,
   bus_share_arb2_if.slave  bus
);

   slot_e            slotQ, slotD;
   logic [WIDTH-1:0] dataQ, dataD;
   logic             srcQ, srcD;
   logic             lastGrant, lastGrantD;
   logic [CNTW-1:0]  cnt0Q, cnt0D, cnt1Q, cnt1D;
   logic             grantVld, grantIdx, canAccept, xfer;
   logic [WIDTH-1:0] muxData;

   function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   rr_pick2 uPick (
      .valid0    (bus.req0_valid),
      .valid1    (bus.req1_valid),
      .lastGrant (lastGrant),
      .grantVld  (grantVld),
      .grantIdx  (grantIdx)
   );

   assign muxData   = (grantIdx == SRC_REQ1) ? bus.req1_data : bus.req0_data;
   assign canAccept = (slotQ == SLOT_EMPTY) || bus.out_ready;
   // Inputs are ignored while reset is held, so no ready may escape
   assign xfer      = rst_n && canAccept && grantVld;

   assign bus.req0_ready = xfer && (grantIdx == SRC_REQ0);
   assign bus.req1_ready = xfer && (grantIdx == SRC_REQ1);
   assign bus.out_valid  = (slotQ == SLOT_FULL);
   assign bus.out_data   = dataQ;
   assign bus.out_src    = srcQ;
   assign bus.grant_cnt0 = cnt0Q;
   assign bus.grant_cnt1 = cnt1Q;

   always_comb begin
      slotD      = slotQ;
      dataD      = dataQ;
      srcD       = srcQ;
      lastGrantD = lastGrant;
      cnt0D      = cnt0Q;
      cnt1D      = cnt1Q;
      if (xfer) begin
         slotD      = SLOT_FULL;
         dataD      = muxData;
         srcD       = grantIdx;
         lastGrantD = grantIdx;
         if (grantIdx == SRC_REQ0) begin
            cnt0D = satInc(cnt0Q);
         end else begin
            cnt1D = satInc(cnt1Q);
         end
      end else if ((slotQ == SLOT_FULL) && bus.out_ready) begin
         slotD = SLOT_EMPTY;
      end
      if (bus.cnt_clr) begin
         cnt0D = '0;
         cnt1D = '0;
      end
   end

   // lastGrant resets to requester 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slotQ     <= SLOT_EMPTY;
         dataQ     <= '0;
         srcQ      <= SRC_REQ0;
         lastGrant <= SRC_REQ1;
         cnt0Q     <= '0;
         cnt1Q     <= '0;
      end else begin
         slotQ     <= slotD;
         dataQ     <= dataD;
         srcQ      <= srcD;
         lastGrant <= lastGrantD;
         cnt0Q     <= cnt0D;
         cnt1Q     <= cnt1D;
      end
   end

endmodule
